// File: rtl/fc_pkg.sv
// fc_pkg: FSM state type and default widths shared by the FC result writer files.
package fc_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
endpackage

// File: rtl/fc_result_writer_if.sv
// fc_result_writer_if: run control, accumulator input handshake and memory write port.
// master drives start/write_base/in_valid/in_acc/in_bias/mem_busy; slave (the writer)
// drives in_ready/mem_we/mem_addr/mem_wdata/finished.
interface fc_result_writer_if #(
    parameter int ADDR_W = fc_pkg::ADDR_W,
    parameter int DATA_W = fc_pkg::DATA_W,
    parameter int ACC_W  = fc_pkg::ACC_W
);
    logic              start;
    logic [ADDR_W-1:0] write_base;
    logic              in_valid;
    logic [ACC_W-1:0]  in_acc;
    logic [DATA_W-1:0] in_bias;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_busy;
    logic              finished;
    modport master (
        output start, write_base, in_valid, in_acc, in_bias, mem_busy,
        input  in_ready, mem_we, mem_addr, mem_wdata, finished
    );
    modport slave (
        input  start, write_base, in_valid, in_acc, in_bias, mem_busy,
        output in_ready, mem_we, mem_addr, mem_wdata, finished
    );
endinterface

// File: rtl/fc_sat_add.sv
// fc_sat_add: res = saturate_DATA_W(acc + sext(bias)), combinational.
// Ports: acc (signed ACC_W), bias (signed DATA_W), res (signed DATA_W).
// Macro FC_WRITER_RELU_EN: negative saturated results become 0.
module fc_sat_add #(
    parameter int ACC_W  = fc_pkg::ACC_W,
    parameter int DATA_W = fc_pkg::DATA_W
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [DATA_W-1:0] bias,
    output logic signed [DATA_W-1:0] res
);
    // one extra bit so the add itself can never overflow before clamping
    localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;
    logic signed [ACC_W:0]    sum;
    logic signed [DATA_W-1:0] sat;
    always_comb begin
        sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-DATA_W){bias[DATA_W-1]}}, bias};
        sat = sum > MAX_V ? MAX_V[DATA_W-1:0] : sum < MIN_V ? MIN_V[DATA_W-1:0] : sum[DATA_W-1:0];
`ifdef FC_WRITER_RELU_EN
        res = sat[DATA_W-1] ? '0 : sat;
`else
        res = sat;
`endif
    end
endmodule

// File: rtl/fc_result_writer.sv
// fc_result_writer: writes NUM_OUT biased, saturated node values to base+i per run.
// Ports: clk, reset (sync, active high), bus (fc_result_writer_if.slave).
// Macro FC_WRITER_RELU_EN (in fc_sat_add) clamps negative results to 0.
module fc_result_writer #(
    parameter int NUM_OUT = 3,
    parameter int ADDR_W  = fc_pkg::ADDR_W,
    parameter int DATA_W  = fc_pkg::DATA_W,
    parameter int ACC_W   = fc_pkg::ACC_W
) (
    input logic               clk,
    input logic               reset,
    fc_result_writer_if.slave bus
);
    import fc_pkg::*;
    localparam int CW = $clog2(NUM_OUT + 1);
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, result;
    logic              we_q, we_d, ready, xfer, accept, last_done;
    fc_sat_add #(.ACC_W(ACC_W), .DATA_W(DATA_W)) u_sat (
        .acc (bus.in_acc),
        .bias(bus.in_bias),
        .res (result)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end
    // at most one write is ever pending, so a new pair is only taken when the
    // write register is empty or draining this cycle
    always_comb begin
        accept    = state_q == IDLE && bus.start;
        ready     = state_q == RUN && cnt_q < CW'(NUM_OUT) && (!we_q || !bus.mem_busy);
        xfer      = ready && bus.in_valid;
        last_done = cnt_q == CW'(NUM_OUT) && (!we_q || !bus.mem_busy);
        state_d   = accept ? RUN : (state_q == RUN && last_done) ? DONE : state_q == DONE ? IDLE : state_q;
        base_d    = accept ? bus.write_base : base_q;
        cnt_d     = accept ? '0 : xfer ? cnt_q + 1'b1 : cnt_q;
        we_d      = xfer || (we_q && bus.mem_busy);
        addr_d    = xfer ? base_q + ADDR_W'(cnt_q) : addr_q;
        wdata_d   = xfer ? result : wdata_q;
    end
    always_comb begin
        bus.in_ready  = ready;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.finished  = state_q == DONE;
    end
endmodule

// File: tb/tb_fc_result_writer.sv
// tb_fc_result_writer: directed and randomized runs of fc_result_writer against a scoreboard.
module tb_fc_result_writer;
    logic clk;
    logic reset;
    int   nvec;
    int   nerr;
    logic [31:0] acc_v [3];
    logic [15:0] bias_v [3];
    fc_result_writer_if bus ();
    fc_result_writer dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [15:0] ref_res(input logic signed [31:0] a, input logic signed [15:0] b);
        longint s;
        s = longint'(a) + longint'(b);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef FC_WRITER_RELU_EN
        if (s < 0) s = 0;
`endif
        return 16'(s);
    endfunction
    task automatic run_layer(input logic [15:0] base, input int valid_pct, input int busy_pct,
                             input int busy_lo, input int busy_hi, input bit glitch, input int fin_at);
        logic [15:0] ea [3];
        logic [15:0] ed [3];
        logic [15:0] pa, pd;
        int sent, wrote, last_wr, k_last;
        bit fin_seen, xfer_prev, hold_prev;
        for (int i = 0; i < 3; i++) begin
            ea[i] = base + 16'(i);
            ed[i] = ref_res(acc_v[i], bias_v[i]);
        end
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.write_base = base;
        bus.in_valid = 1'b0;
        bus.mem_busy = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        sent = 0; wrote = 0; last_wr = -10; k_last = 0;
        fin_seen = 0; xfer_prev = 0; hold_prev = 0; pa = '0; pd = '0;
        for (int c = 0; c < 300 && !fin_seen; c++) begin
            bus.start = glitch && c == 1;
            if (glitch && c == 1) bus.write_base = ~base;
            bus.in_valid = sent < 3 && $urandom_range(99) < valid_pct;
            bus.in_acc = acc_v[sent < 3 ? sent : 2];
            bus.in_bias = bias_v[sent < 3 ? sent : 2];
            bus.mem_busy = (c >= busy_lo && c <= busy_hi) || $urandom_range(99) < busy_pct;
            @(negedge clk);
            if (xfer_prev) begin
                chk("lat_we", 32'(bus.mem_we), 32'(1));
                chk("lat_addr", 32'(bus.mem_addr), 32'(ea[k_last]));
                chk("lat_data", 32'(bus.mem_wdata), 32'(ed[k_last]));
            end
            if (hold_prev) begin
                chk("hold_we", 32'(bus.mem_we), 32'(1));
                chk("hold_addr", 32'(bus.mem_addr), 32'(pa));
                chk("hold_data", 32'(bus.mem_wdata), 32'(pd));
            end
            if (bus.mem_we && bus.mem_busy) chk("stall_rdy", 32'(bus.in_ready), 32'(0));
            if (bus.mem_we && !bus.mem_busy) begin
                chk("wr_over", 32'(wrote < 3), 32'(1));
                chk("wr_addr", 32'(bus.mem_addr), 32'(ea[wrote < 3 ? wrote : 2]));
                chk("wr_data", 32'(bus.mem_wdata), 32'(ed[wrote < 3 ? wrote : 2]));
                wrote++;
                last_wr = c;
            end
            if (bus.finished) begin
                fin_seen = 1;
                chk("fin_cnt", 32'(wrote), 32'(3));
                chk("fin_time", 32'(c), 32'(last_wr + 1));
                chk("fin_we", 32'(bus.mem_we), 32'(0));
                if (fin_at >= 0) chk("fin_at", 32'(c), 32'(fin_at));
            end
            xfer_prev = bus.in_valid && bus.in_ready;
            if (xfer_prev) begin
                k_last = sent;
                sent++;
            end
            hold_prev = bus.mem_we && bus.mem_busy;
            pa = bus.mem_addr;
            pd = bus.mem_wdata;
            @(posedge clk); #1;
        end
        chk("timeout", 32'(fin_seen), 32'(1));
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.mem_busy = 1'b0;
        @(negedge clk);
        chk("idle_rdy", 32'(bus.in_ready), 32'(0));
        chk("idle_we", 32'(bus.mem_we), 32'(0));
        chk("idle_fin", 32'(bus.finished), 32'(0));
    endtask
    initial begin
        nvec = 0;
        nerr = 0;
        bus.start = 1'b0;
        bus.write_base = '0;
        bus.in_valid = 1'b0;
        bus.in_acc = '0;
        bus.in_bias = '0;
        bus.mem_busy = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 32'(bus.mem_we), 32'(0));
        chk("rst_addr", 32'(bus.mem_addr), 32'(0));
        chk("rst_data", 32'(bus.mem_wdata), 32'(0));
        chk("rst_rdy", 32'(bus.in_ready), 32'(0));
        chk("rst_fin", 32'(bus.finished), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        acc_v[0] = 32'd10; acc_v[1] = 32'hFFFF_FFEC; acc_v[2] = 32'd7;
        bias_v[0] = 16'd1; bias_v[1] = 16'd2; bias_v[2] = 16'hFFFD;
        run_layer(16'h0100, 100, 0, -1, -1, 1'b0, 4);
        acc_v[0] = 32'h0001_0000; acc_v[1] = 32'hFFFF_0000; acc_v[2] = 32'h7FFF_FFFF;
        bias_v[0] = 16'd5; bias_v[1] = 16'd0; bias_v[2] = 16'h7FFF;
        run_layer(16'h0300, 100, 0, -1, -1, 1'b0, 4);
        for (int i = 0; i < 3; i++) begin
            acc_v[i] = $urandom_range(40000) - 20000;
            bias_v[i] = 16'($urandom_range(200));
        end
        run_layer(16'h0400, 100, 0, 1, 3, 1'b0, 7);
        run_layer(16'hFFFF, 100, 0, -1, -1, 1'b1, 4);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.write_base = 16'h0200;
        bus.in_valid = 1'b1;
        bus.in_acc = 32'd100;
        bus.in_bias = 16'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.mem_busy = 1'b1;
        @(negedge clk);
        chk("rs_we", 32'(bus.mem_we), 32'(1));
        chk("rs_addr", 32'(bus.mem_addr), 32'h0201);
        chk("rs_rdy", 32'(bus.in_ready), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rs_hold", 32'(bus.mem_addr), 32'h0201);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rs_drop_we", 32'(bus.mem_we), 32'(0));
        chk("rs_drop_rdy", 32'(bus.in_ready), 32'(0));
        chk("rs_drop_addr", 32'(bus.mem_addr), 32'(0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rs_no_fin", 32'(bus.finished), 32'(0));
            chk("rs_no_we", 32'(bus.mem_we), 32'(0));
        end
        bus.mem_busy = 1'b0;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 3; i++) begin
                acc_v[i] = $urandom_range(1) ? $urandom : $urandom_range(40000) - 20000;
                bias_v[i] = 16'($urandom);
            end
            run_layer(16'($urandom), 70, 30, -1, -1, 1'($urandom_range(1)), -1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/fc_result_writer.md
FC_RESULT_WRITER -- requirements
Module: fc_result_writer

Interface
REQ-001 Parameter NUM_OUT, default 3, number of output nodes written per layer run.
REQ-002 Parameter ADDR_W, default 16, memory address width.
REQ-003 Parameter DATA_W, default 16, memory word width (signed node value).
REQ-004 Parameter ACC_W, default 32, incoming accumulator width (signed).
REQ-005 clk  input  1  single clock; all logic on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-008 write_base  input  ADDR_W  base address for node 0; captured on accepted start.
REQ-009 in_valid  input  1  accumulator/bias pair present.
REQ-010 in_acc  input  ACC_W  signed dot-product sum for current node.
REQ-011 in_bias  input  DATA_W  signed bias for current node.
REQ-012 in_ready  output  1  writer accepts the pair this cycle.
REQ-013 mem_we  output  1  memory write strobe.
REQ-014 mem_addr  output  ADDR_W  write address.
REQ-015 mem_wdata  output  DATA_W  write data.
REQ-016 mem_busy  input  1  memory stall; write held while high.
REQ-017 finished  output  1  one-cycle pulse after last write is accepted.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DONE.
REQ-019 IDLE->RUN on start; write_base captured, node counter cleared to 0; start in RUN/DONE ignored.
REQ-020 in_ready SHALL be high only in RUN, with counter < NUM_OUT, and (mem_we low or mem_busy low).
REQ-021 Transfer occurs when in_valid and in_ready are both high; exactly one node per transfer.
REQ-022 Result = in_acc + sign-extended in_bias computed at ACC_W+1 bits, then saturated to signed DATA_W range (max 0x7FFF, min 0x8000 at default width).
REQ-023 Latency: transfer in cycle N drives mem_we=1, mem_addr=base+counter, mem_wdata=result in cycle N+1.
REQ-024 mem_we, mem_addr, mem_wdata SHALL hold unchanged while mem_busy is high; write completes on the first cycle with mem_we high and mem_busy low.
REQ-025 Back-to-back transfers SHALL sustain one write per cycle when mem_busy is low.
REQ-026 Counter increments on each transfer; address wraps modulo 2^ADDR_W without error.
REQ-027 RUN->DONE when NUM_OUT writes have completed; DONE asserts finished for one cycle then returns to IDLE.
REQ-028 mem_we SHALL be low in IDLE and DONE; no write issued beyond NUM_OUT per run.

Reset
REQ-029 On reset: state IDLE, counter 0, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, finished 0.
REQ-030 Reset mid-run SHALL drop any pending/stalled write the following cycle and not assert finished.

Configuration
REQ-031 Macro FC_WRITER_RELU_EN: when defined, negative saturated results SHALL be written as 0; when undefined, signed saturated value written unchanged.

Structure
REQ-032 Shared package fc_pkg SHALL hold the FSM state enum and the default width constants (ADDR_W, DATA_W, ACC_W).
REQ-033 Sub-module fc_sat_add SHALL implement the bias add, saturation and optional ReLU combinationally.

Verification
REQ-034 base=0x0100, acc {10,-20,7}, bias {1,2,-3}, mem_busy=0 -> writes 0x0100=11, 0x0101=-18, 0x0102=4, finished one cycle after third write.
REQ-035 acc=0x00010000, bias=5 -> wdata 0x7FFF; acc=0xFFFF0000, bias=0 -> 0x8000 (0x0000 with FC_WRITER_RELU_EN).
REQ-036 mem_busy high 3 cycles during first write -> mem_we/addr/wdata stable, in_ready low, no transfer lost, 3 writes total.
REQ-037 start pulsed during RUN -> ignored, base unchanged; base=0xFFFF, NUM_OUT=3 -> addresses 0xFFFF, 0x0000, 0x0001.
REQ-038 reset asserted while mem_busy stalls second write -> mem_we 0 next cycle, state IDLE, finished never asserted.
